// File: rtl/rr_ray_arbiter.sv
// rtl/rr_ray_arbiter.sv - round-robin arbiter for a shared in-order ray datapath unit
//
// Shares one ready/valid compute unit among NUM_REQ ray requesters. Each
// issued request has its requester index pushed into an ID FIFO. Results
// come back in issue order and are routed to the requester at the FIFO head.
// A credit count (inflight) caps outstanding requests at MAX_INFLIGHT.
//
// Optional build macro: RR_ARB_PERF_EN enables the saturating stall counter
// on perf_stall_cnt. Without the macro, perf_stall_cnt is tied to zero.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/data/ready  per-requester request channel (data packed, DATA_W each)
//   dn_valid/data/id      granted request to the shared unit; dn_ready back-pressure
//   up_valid/data         in-order result from the shared unit; up_ready accept
//   resp_valid/data       one-hot result valid with broadcast payload; resp_ready accept
//   perf_stall_cnt        cycles with a pending request and no issue
module rr_ray_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 32,
  parameter int MAX_INFLIGHT = 4,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dn_valid,
  output logic [DATA_W-1:0]         dn_data,
  output logic [ID_W-1:0]           dn_id,
  input  logic                      dn_ready,
  input  logic                      up_valid,
  input  logic [DATA_W-1:0]         up_data,
  output logic                      up_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [15:0]               perf_stall_cnt
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0] r_inflight;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [ID_W-1:0]  r_fifo [MAX_INFLIGHT];
  logic             r_locked;
  logic [ID_W-1:0]  r_lock_g;

  logic             w_found;
  logic [ID_W-1:0]  w_scan_g;
  int               w_idx;
  logic [ID_W-1:0]  w_grant;
  logic             w_req;
  logic             w_credit_ok;
  logic             w_issue;
  logic [ID_W-1:0]  w_head;
  logic             w_nonempty;
  logic             w_pop;

  // Rotating priority scan starting at r_rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_scan_g = '0;
    w_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_scan_g = ID_W'(w_idx);
      end
    end
  end

  // A grant that was offered but not taken is held so a newly arriving
  // higher-priority requester cannot swap dn_id/dn_data mid-handshake.
  always_comb begin
    if (r_locked) begin
      w_grant = r_lock_g;
      w_req   = req_valid[r_lock_g];
    end else begin
      w_grant = w_scan_g;
      w_req   = w_found;
    end
  end

  assign w_credit_ok = (r_inflight < CNT_W'(MAX_INFLIGHT));

  // Outputs are gated by rst_n so they read zero while reset is held.
  assign dn_valid  = rst_n && w_req && w_credit_ok;
  assign dn_data   = req_data[int'(w_grant)*DATA_W +: DATA_W];
  assign dn_id     = w_grant;
  assign req_ready = (dn_valid && dn_ready) ? (NUM_REQ'(1) << w_grant) : '0;
  assign w_issue   = dn_valid && dn_ready;

  assign w_head     = r_fifo[r_rd_ptr];
  assign w_nonempty = (r_inflight != '0);
  assign up_ready   = rst_n && w_nonempty && resp_ready[w_head];
  assign resp_valid = (rst_n && up_valid && w_nonempty) ? (NUM_REQ'(1) << w_head) : '0;
  assign resp_data  = up_data;
  assign w_pop      = up_valid && up_ready;

  // FIFO storage carries no reset: occupancy is tracked by r_inflight.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_fifo[r_wr_ptr] <= w_grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_locked   <= 1'b0;
      r_lock_g   <= '0;
    end else begin
      if (w_issue) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_rr_ptr <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_issue, w_pop})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      r_locked <= dn_valid && !dn_ready;
      r_lock_g <= w_grant;
    end
  end

`ifdef RR_ARB_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((|req_valid) && !w_issue && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_ray_arbiter.sv
// tb/tb_rr_ray_arbiter.sv - directed self-checking bench for rr_ray_arbiter
module tb_rr_ray_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 32;
  localparam int MAX_INFLIGHT = 4;
  localparam int ID_W         = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      dn_valid;
  logic [DATA_W-1:0]         dn_data;
  logic [ID_W-1:0]           dn_id;
  logic                      dn_ready;
  logic                      up_valid;
  logic [DATA_W-1:0]         up_data;
  logic                      up_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [15:0]               perf_stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_ray_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .dn_valid(dn_valid),
    .dn_data(dn_data),
    .dn_id(dn_id),
    .dn_ready(dn_ready),
    .up_valid(up_valid),
    .up_data(up_data),
    .up_ready(up_ready),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_ready(resp_ready),
    .perf_stall_cnt(perf_stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid  = '0;
    dn_ready   = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    resp_ready = '0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    idle();
    req_valid = 4'b1111;
    dn_ready  = 1'b1;
    #1;
    n_vec++; if (dn_valid !== 1'b0) begin n_err++; $display("FAIL rst_dn_valid got %b exp 0", dn_valid); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
    n_vec++; if (up_ready !== 1'b0) begin n_err++; $display("FAIL rst_up_ready got %b exp 0", up_ready); end
    n_vec++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL rst_resp_valid got %b exp 0000", resp_valid); end
    n_vec++; if (perf_stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_perf got %0d exp 0", perf_stall_cnt); end
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < 10; k++) begin
      tick();
      resp_ready = 4'b1111;
      up_valid   = 1'b1;
      #1;
      n_vec++; if (dn_valid !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL idle_dn cyc %0d got dn_valid=%b req_ready=%b exp 0/0000", k, dn_valid, req_ready); end
      n_vec++; if (up_ready !== 1'b0 || resp_valid !== 4'b0000) begin n_err++; $display("FAIL idle_up cyc %0d got up_ready=%b resp_valid=%b exp 0/0000", k, up_ready, resp_valid); end
    end
    idle();
  endtask

  task automatic test_round_robin();
    logic [ID_W-1:0] exp_id;
    logic [NUM_REQ-1:0] exp_rv;
    for (int k = 0; k < 8; k++) begin
      tick();
      req_valid  = 4'b1111;
      dn_ready   = 1'b1;
      up_valid   = 1'b1;
      resp_ready = 4'b1111;
      up_data    = 32'hC0DE_0000 + k;
      #1;
      exp_id = ID_W'(k % 4);
      exp_rv = (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
      n_vec++; if (dn_valid !== 1'b1 || dn_id !== exp_id) begin n_err++; $display("FAIL rr_grant cyc %0d got valid=%b id=%0d exp 1/%0d", k, dn_valid, dn_id, exp_id); end
      n_vec++; if (dn_data !== (32'hA5A5_0000 | 32'(exp_id))) begin n_err++; $display("FAIL rr_data cyc %0d got %h exp %h", k, dn_data, 32'hA5A5_0000 | 32'(exp_id)); end
      n_vec++; if (req_ready !== (4'b0001 << exp_id)) begin n_err++; $display("FAIL rr_req_ready cyc %0d got %b exp %b", k, req_ready, 4'b0001 << exp_id); end
      n_vec++; if (resp_valid !== exp_rv || up_ready !== (k != 0)) begin n_err++; $display("FAIL rr_return cyc %0d got resp_valid=%b up_ready=%b exp %b/%b", k, resp_valid, up_ready, exp_rv, (k != 0)); end
    end
    tick();
    req_valid = 4'b0000;
    up_data   = 32'h1234_5678;
    #1;
    n_vec++; if (resp_valid !== 4'b1000 || resp_data !== 32'h1234_5678) begin n_err++; $display("FAIL rr_drain got %b/%h exp 1000/12345678", resp_valid, resp_data); end
    tick();
    #1;
    n_vec++; if (up_ready !== 1'b0 || resp_valid !== 4'b0000) begin n_err++; $display("FAIL rr_empty got up_ready=%b resp_valid=%b exp 0/0000", up_ready, resp_valid); end
    idle();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      tick();
      req_valid  = 4'b0100;
      dn_ready   = 1'b1;
      resp_ready = 4'b1111;
      #1;
      n_vec++; if (dn_valid !== 1'b1 || dn_id !== 2'd2 || req_ready !== 4'b0100) begin n_err++; $display("FAIL full_issue %0d got %b/%0d/%b exp 1/2/0100", k, dn_valid, dn_id, req_ready); end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++; if (dn_valid !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL full_block %0d got %b/%b exp 0/0000", k, dn_valid, req_ready); end
    end
    tick();
    up_valid = 1'b1;
    up_data  = 32'h0000_BEEF;
    #1;
    n_vec++; if (resp_valid !== 4'b0100 || up_ready !== 1'b1 || resp_data !== 32'h0000_BEEF) begin n_err++; $display("FAIL full_return got %b/%b/%h exp 0100/1/0000beef", resp_valid, up_ready, resp_data); end
    n_vec++; if (dn_valid !== 1'b0) begin n_err++; $display("FAIL full_same_cycle got %b exp 0", dn_valid); end
    tick();
    up_valid = 1'b0;
    #1;
    n_vec++; if (dn_valid !== 1'b1 || req_ready !== 4'b0100) begin n_err++; $display("FAIL full_resume got %b/%b exp 1/0100", dn_valid, req_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      req_valid = 4'b0000;
      up_valid  = 1'b1;
      #1;
      n_vec++; if (resp_valid !== 4'b0100 || up_ready !== 1'b1) begin n_err++; $display("FAIL full_drain %0d got %b/%b exp 0100/1", k, resp_valid, up_ready); end
    end
    tick();
    n_vec++; if (up_ready !== 1'b0 || resp_valid !== 4'b0000) begin n_err++; $display("FAIL full_empty got %b/%b exp 0/0000", up_ready, resp_valid); end
    idle();
  endtask

  task automatic test_in_order();
    logic [ID_W-1:0] ids [3];
    ids[0] = 2'd3;
    ids[1] = 2'd0;
    ids[2] = 2'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      req_valid = 4'b0001 << ids[k];
      dn_ready  = 1'b1;
      #1;
      n_vec++; if (dn_valid !== 1'b1 || dn_id !== ids[k]) begin n_err++; $display("FAIL order_issue %0d got %b/%0d exp 1/%0d", k, dn_valid, dn_id, ids[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      req_valid  = 4'b0000;
      up_valid   = 1'b1;
      resp_ready = 4'b1111;
      #1;
      n_vec++; if (resp_valid !== (4'b0001 << ids[k]) || up_ready !== 1'b1) begin n_err++; $display("FAIL order_return %0d got %b/%b exp %b/1", k, resp_valid, up_ready, 4'b0001 << ids[k]); end
    end
    tick();
    n_vec++; if (up_ready !== 1'b0 || resp_valid !== 4'b0000) begin n_err++; $display("FAIL order_empty got %b/%b exp 0/0000", up_ready, resp_valid); end
    idle();
  endtask

  task automatic test_backpressure();
    tick();
    req_valid = 4'b0010;
    dn_ready  = 1'b1;
    #1;
    n_vec++; if (dn_id !== 2'd1 || req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_issue got %0d/%b exp 1/0010", dn_id, req_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      req_valid  = 4'b0000;
      dn_ready   = 1'b0;
      up_valid   = 1'b1;
      resp_ready = 4'b1101;
      #1;
      n_vec++; if (up_ready !== 1'b0 || resp_valid !== 4'b0010) begin n_err++; $display("FAIL bp_hold %0d got %b/%b exp 0/0010", k, up_ready, resp_valid); end
    end
    tick();
    resp_ready = 4'b1111;
    #1;
    n_vec++; if (up_ready !== 1'b1 || resp_valid !== 4'b0010) begin n_err++; $display("FAIL bp_release got %b/%b exp 1/0010", up_ready, resp_valid); end
    tick();
    n_vec++; if (up_ready !== 1'b0 || resp_valid !== 4'b0000) begin n_err++; $display("FAIL bp_single_pop got %b/%b exp 0/0000", up_ready, resp_valid); end
    idle();
  endtask

  task automatic test_stall_and_lock();
    logic [15:0] exp_perf;
`ifdef RR_ARB_PERF_EN
    exp_perf = 16'd7;
`else
    exp_perf = 16'd0;
`endif
    tick();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < 7; k++) begin
      tick();
      req_valid = 4'b0001;
      dn_ready  = 1'b0;
      #1;
      n_vec++; if (dn_valid !== 1'b1 || dn_id !== 2'd0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL stall %0d got %b/%0d/%b exp 1/0/0000", k, dn_valid, dn_id, req_ready); end
    end
    tick();
    n_vec++; if (perf_stall_cnt !== exp_perf) begin n_err++; $display("FAIL perf_stall got %0d exp %0d", perf_stall_cnt, exp_perf); end
    dn_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL stall_accept got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b1000;
    dn_ready  = 1'b0;
    #1;
    n_vec++; if (dn_id !== 2'd3) begin n_err++; $display("FAIL lock_first got %0d exp 3", dn_id); end
    tick();
    req_valid = 4'b1010;
    #1;
    n_vec++; if (dn_id !== 2'd3 || dn_data !== 32'hA5A5_0003) begin n_err++; $display("FAIL lock_hold got %0d/%h exp 3/a5a50003", dn_id, dn_data); end
    tick();
    dn_ready = 1'b1;
    #1;
    n_vec++; if (dn_id !== 2'd3 || req_ready !== 4'b1000) begin n_err++; $display("FAIL lock_accept got %0d/%b exp 3/1000", dn_id, req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_mid_reset();
    tick();
    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    dn_ready   = 1'b1;
    up_valid   = 1'b1;
    resp_ready = 4'b1111;
    #1;
    n_vec++; if (dn_valid !== 1'b0 || req_ready !== 4'b0000 || up_ready !== 1'b0 || resp_valid !== 4'b0000) begin n_err++; $display("FAIL mid_rst got %b/%b/%b/%b exp 0/0000/0/0000", dn_valid, req_ready, up_ready, resp_valid); end
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    #1;
    n_vec++; if (up_ready !== 1'b0 || resp_valid !== 4'b0000) begin n_err++; $display("FAIL post_rst_ignore got %b/%b exp 0/0000", up_ready, resp_valid); end
    tick();
    req_valid = 4'b0011;
    up_valid  = 1'b0;
    #1;
    n_vec++; if (dn_id !== 2'd0 || req_ready !== 4'b0001) begin n_err++; $display("FAIL post_rst_issue got %0d/%b exp 0/0001", dn_id, req_ready); end
    idle();
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = 32'hA5A5_0000 | 32'(i);
    end
    test_reset();
    test_round_robin();
    test_full();
    test_in_order();
    test_backpressure();
    test_stall_and_lock();
    test_mid_reset();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_ray_arbiter.md
Name: rr_ray_arbiter

Overview:
- Round-robin arbiter sharing one fixed-order, ready/valid ray datapath unit (e.g. intersection pipeline) among NUM_REQ ray requesters.
- Tracks in-flight transactions with a credit counter and an ID FIFO, and routes in-order results back to the originating requester.
- Sits between the per-lane ray generators and the shared compute unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, request and result payload width.
- MAX_INFLIGHT, 4, maximum outstanding issued-but-unreturned requests (power of 2, >=2).
- ID_W, $clog2(NUM_REQ), derived requester index width; not overridden.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*DATA_W  packed payloads; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester accept.
- dn_valid  out  1  request to shared unit valid.
- dn_data  out  DATA_W  payload of granted requester.
- dn_id  out  ID_W  index of granted requester.
- dn_ready  in  1  shared unit accepts.
- up_valid  in  1  result from shared unit valid (results return in issue order).
- up_data  in  DATA_W  result payload.
- up_ready  out  1  arbiter accepts result.
- resp_valid  out  NUM_REQ  one-hot result valid to requester.
- resp_data  out  DATA_W  result payload, broadcast to all requesters.
- resp_ready  in  NUM_REQ  per-requester result accept.
- perf_stall_cnt  out  16  stall counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr=0, inflight=0, ID FIFO empty, perf_stall_cnt=0.
  - req_ready=0, dn_valid=0, up_ready=0, resp_valid=0.
- credit_ok = (inflight < MAX_INFLIGHT).
- Grant (combinational):
  - First requester with req_valid set, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - dn_valid = any req_valid && credit_ok.
  - dn_data / dn_id = granted requester's payload / index.
  - req_ready[g] = dn_ready && credit_ok; all other req_ready bits 0.
- Issue handshake (dn_valid && dn_ready):
  - Push g into ID FIFO.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Zero latency: request accepted in the same cycle it is presented.
- No handshake: rr_ptr holds.
- Once dn_valid is asserted, grant, dn_data and dn_id stay stable until dn_ready, provided requesters hold req_valid (AXI-style). A requester that drops req_valid is a protocol violation and is not checked.
- Return path, head = ID FIFO head:
  - up_ready = (inflight != 0) && resp_ready[head].
  - resp_valid[head] = up_valid && (inflight != 0); other bits 0.
  - resp_data = up_data.
  - On up_valid && up_ready: pop FIFO.
- inflight update, per cycle: +1 on issue only, -1 on return only, unchanged on simultaneous issue and return.
  - Simultaneous issue and return at inflight=MAX_INFLIGHT is impossible, since issue is blocked when full.
  - Simultaneous at inflight=0: pop is blocked (up_ready=0); the issue is counted.
- up_valid while inflight=0: ignored, up_ready=0, nothing routed.
- Full (inflight=MAX_INFLIGHT): dn_valid=0 and all req_ready=0 until a return occurs. The issue resumes the cycle after the pop.
- FIFO pointers wrap modulo MAX_INFLIGHT. Count is held in $clog2(MAX_INFLIGHT)+1 bits.
- Reset mid-operation: all in-flight tracking is discarded. Results arriving later with inflight=0 are ignored as above.

Optional Feature:
- Macro: RR_ARB_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle with (|req_valid) && !(dn_valid && dn_ready).
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: perf_stall_cnt tied to 0; no counter logic generated.

Test Plan:
- Reset then idle, NUM_REQ=4 -> all outputs 0, rr_ptr=0; no dn_valid for 10 cycles.
- req_valid=4'b1111 held, dn_ready=1, up_valid returning each cycle -> dn_id sequence 0,1,2,3,0,1...; each requester gets exactly one grant per 4 issues.
- req_valid=4'b0100 only, dn_ready=1, no returns -> exactly 4 issues with dn_id=2, then dn_valid=0 and req_ready=0 (full). One up_valid beat -> resp_valid=4'b0100, and one more issue the next cycle.
- Issue ids 3,0,1 in order, then return 3 results with resp_ready=4'b1111 -> resp_valid one-hot 4'b1000, 4'b0001, 4'b0010 in that order; inflight back to 0.
- Head id=1 with resp_ready[1]=0 for 5 cycles while up_valid=1 -> up_ready=0 and resp_valid[1]=1 held 5 cycles; no pop. On resp_ready[1]=1, a single pop.
- RR_ARB_PERF_EN defined, req_valid=4'b0001, dn_ready=0 for 7 cycles -> perf_stall_cnt=7. Undefined -> perf_stall_cnt stays 0.
